forward_hazard_unit: RTL

Sequencing controller for the EX-stage operand 4-to-1 muxes of the pipelined MIPS datapath. It keeps a shadow pipeline of destination-register information for EX, MEM, WB and one post-WB stage. From that it drives the two-bit select pairs of the ALU operand A and B muxes, and it detects load-use hazards, stalling IF/ID and inserting a bubble into ID/EX. A saturating stall counter is provided for performance measurement.

---
 rtl/forward_hazard_unit_pkg.sv | 30 +++
 rtl/forward_hazard_unit_if.sv | 35 +++
 rtl/forward_hazard_unit_fwd_operand_select.sv | 39 +++
 rtl/forward_hazard_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding/hazard controller:
// operand-mux select codes and the shadow pipeline stage records.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [1:0] FWD_PWB = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Destination information carried by every shadow stage.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic [4:0] write_reg;
  } stage_t;

  // The EX stage also remembers which registers its instruction reads.
  typedef struct packed {
    stage_t     dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
  } ex_stage_t;

  localparam stage_t    STAGE_BUBBLE = '0;
  localparam ex_stage_t EX_BUBBLE    = '0;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// ID-stage instruction info into the hazard unit, mux selects and stall out.
//
// Handshake: ID_Valid marks a real instruction in ID. Stall is the
// back-pressure; the instruction is accepted into EX on a clock edge only
// when ID_Valid=1, Stall=0 and Flush=0, otherwise EX receives a bubble.
interface forward_hazard_unit_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   ID_Valid;
  logic [4:0]             ID_Rs;
  logic [4:0]             ID_Rt;
  logic                   ID_UsesRt;
  logic                   ID_RegWrite;
  logic                   ID_MemRead;
  logic [4:0]             ID_WriteReg;
  logic                   Flush;
  logic                   FwdA_c1;
  logic                   FwdA_c2;
  logic                   FwdB_c1;
  logic                   FwdB_c2;
  logic                   Stall;
  logic [STALL_CNT_W-1:0] StallCount;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_UsesRt, ID_RegWrite, ID_MemRead,
           ID_WriteReg, Flush,
    input  FwdA_c1, FwdA_c2, FwdB_c1, FwdB_c2, Stall, StallCount
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRt, ID_RegWrite, ID_MemRead,
           ID_WriteReg, Flush,
    output FwdA_c1, FwdA_c2, FwdB_c1, FwdB_c2, Stall, StallCount
  );
endinterface

// File: rtl/forward_hazard_unit_fwd_operand_select.sv
// Combinational select for one ALU operand mux: the nearest downstream
// producer of the source register wins, register $0 is never forwarded.
module fwd_operand_select
  import hazard_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  stage_t     mem_i,
  input  stage_t     wb_i,
  input  stage_t     pwb_i,
  output logic [1:0] sel_o
);

  logic mem_hit;
  logic wb_hit;
  logic pwb_hit;
  logic unused_mem_read;

  assign mem_hit = mem_i.reg_write && (mem_i.write_reg == src_i);
  assign wb_hit  = wb_i.reg_write  && (wb_i.write_reg  == src_i);
  assign pwb_hit = pwb_i.reg_write && (pwb_i.write_reg == src_i);

  // Load status does not matter once a value has left EX.
  assign unused_mem_read = mem_i.mem_read ^ wb_i.mem_read ^ pwb_i.mem_read;

  always_comb begin
    sel_o = FWD_RF;
    if (use_i && (src_i != REG_ZERO)) begin
      if (mem_hit) begin
        sel_o = FWD_MEM;
      end else if (wb_hit) begin
        sel_o = FWD_WB;
      end else if (pwb_hit) begin
        sel_o = FWD_PWB;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard controller: shadow pipeline of destination
// info (EX/MEM/WB/post-WB), operand mux selects, stall and stall counter.
module forward_hazard_unit
  import hazard_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input logic                  Clk,
  input logic                  Reset,
  forward_hazard_unit_if.slave bus
);

  ex_stage_t              ex_q;
  ex_stage_t              ex_d;
  stage_t                 mem_q;
  stage_t                 wb_q;
  stage_t                 pwb_q;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;

  logic                   stall;
  logic                   load_in_ex;
  logic                   rs_dep;
  logic                   rt_dep;
  logic [1:0]             sel_a;
  logic [1:0]             sel_b;

  // A load into $0 produces nothing to wait for.
  always_comb begin
    load_in_ex = ex_q.dst.reg_write && ex_q.dst.mem_read &&
                 (ex_q.dst.write_reg != REG_ZERO);
    rs_dep     = (ex_q.dst.write_reg == bus.ID_Rs);
    rt_dep     = bus.ID_UsesRt && (ex_q.dst.write_reg == bus.ID_Rt);
    stall      = bus.ID_Valid && !bus.Flush && load_in_ex && (rs_dep || rt_dep);
  end

  always_comb begin
    ex_d = EX_BUBBLE;
    if (bus.ID_Valid && !stall && !bus.Flush) begin
      ex_d.dst.reg_write = bus.ID_RegWrite;
      ex_d.dst.mem_read  = bus.ID_MemRead;
      ex_d.dst.write_reg = bus.ID_WriteReg;
      ex_d.rs            = bus.ID_Rs;
      ex_d.rt            = bus.ID_Rt;
      ex_d.uses_rt       = bus.ID_UsesRt;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // No downstream stall exists, so the shadow stages shift every cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_q  <= EX_BUBBLE;
      mem_q <= STAGE_BUBBLE;
      wb_q  <= STAGE_BUBBLE;
      pwb_q <= STAGE_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q.dst;
      wb_q  <= mem_q;
      pwb_q <= wb_q;
      cnt_q <= cnt_d;
    end
  end

  fwd_operand_select u_sel_a (
    .src_i (ex_q.rs),
    .use_i (1'b1),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .pwb_i (pwb_q),
    .sel_o (sel_a)
  );

  fwd_operand_select u_sel_b (
    .src_i (ex_q.rt),
    .use_i (ex_q.uses_rt),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .pwb_i (pwb_q),
    .sel_o (sel_b)
  );

  assign {bus.FwdA_c1, bus.FwdA_c2} = sel_a;
  assign {bus.FwdB_c1, bus.FwdB_c2} = sel_b;
  assign bus.Stall                  = stall;
  assign bus.StallCount             = cnt_q;

endmodule
